// File: rtl/wait_state_ctr.sv
// wait_state_ctr: loadable down-counter timing external memory wait states
// for the cache memory controller. The controller loads WAITSTATES-1 when it
// enters a miss or system-access state and polls Carry to leave the wait.
//
// Optional build macro: WSC_STICKY_CARRY_EN
//   defined   - expiry parks the counter in DONE with Carry held high until the
//               next Load or reset.
//   undefined - Carry is a single-cycle pulse and the counter returns to IDLE.
module wait_state_ctr #(
  parameter int WIDTH = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadValue,
  output logic             Carry,
  output logic [WIDTH-1:0] Count,
  output logic             Busy
);

  // State encoding kept as plain constants so it matches the legacy netlists.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] COUNT = 2'd1;
`ifdef WSC_STICKY_CARRY_EN
  localparam logic [1:0] DONE  = 2'd2;
`endif

  logic [1:0]       stateReg;
  logic [1:0]       stateNext;
  logic [WIDTH-1:0] countReg;
  logic [WIDTH-1:0] countNext;
  logic             countIsZero;

  assign countIsZero = (countReg == '0);

  // Next-state and next-count: a Load always wins over decrement and expiry.
  always_comb begin
    stateNext = stateReg;
    countNext = countReg;
    case (stateReg)
      IDLE: begin
        if (Load) begin
          countNext = LoadValue;
          stateNext = COUNT;
        end
      end
      COUNT: begin
        if (Load) begin
          countNext = LoadValue;
          stateNext = COUNT;
        end else if (!countIsZero) begin
          countNext = countReg - 1'b1;
        end else begin
`ifdef WSC_STICKY_CARRY_EN
          stateNext = DONE;
`else
          stateNext = IDLE;
`endif
        end
      end
`ifdef WSC_STICKY_CARRY_EN
      DONE: begin
        if (Load) begin
          countNext = LoadValue;
          stateNext = COUNT;
        end
      end
`endif
      default: begin
        // Unreachable encodings recover to a clean idle counter.
        stateNext = IDLE;
        countNext = '0;
      end
    endcase
  end

  // State and count registers; reset clears everything asynchronously so an
  // aborted sequence drops Busy and Carry without waiting for a clock.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stateReg <= IDLE;
      countReg <= '0;
    end else begin
      stateReg <= stateNext;
      countReg <= countNext;
    end
  end

  // Outputs come straight from the registers plus a single compare.
  always_comb begin
    Busy  = (stateReg == COUNT);
    Count = countReg;
`ifdef WSC_STICKY_CARRY_EN
    Carry = ((stateReg == COUNT) && countIsZero) || (stateReg == DONE);
`else
    Carry = (stateReg == COUNT) && countIsZero;
`endif
  end

endmodule

// File: tb/tb_wait_state_ctr.sv
// Self-checking bench for wait_state_ctr: directed scenarios followed by
// random Load/LoadValue/reset traffic, compared against a timeline model.
module tb_wait_state_ctr;

  localparam int WIDTH = 2;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             Load;
  logic [WIDTH-1:0] LoadValue;
  logic             Carry;
  logic [WIDTH-1:0] Count;
  logic             Busy;

  int checks   = 0;
  int failures = 0;

  // Model: a sequence is described only by the edge it was loaded on and the
  // loaded value; outputs follow from the elapsed edge count.
  int edgeCount = 0;
  int loadEdge  = 0;
  int loadVal   = 0;
  bit hasSeq    = 1'b0;

  wait_state_ctr #(.WIDTH(WIDTH)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Load      (Load),
    .LoadValue (LoadValue),
    .Carry     (Carry),
    .Count     (Count),
    .Busy      (Busy)
  );

  always #5 Clk = ~Clk;

  task automatic checkValue(input string tag, input logic [31:0] actual,
                            input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (edge %0d)", tag, actual, expected, edgeCount);
    end
  endtask

  task automatic checkOutputs(input string tag);
    int  e;
    bit  busyExp;
    bit  carryExp;
    int  countExp;
    e        = edgeCount - loadEdge - 1;
    busyExp  = hasSeq && (e <= loadVal);
    countExp = busyExp ? (loadVal - e) : 0;
`ifdef WSC_STICKY_CARRY_EN
    carryExp = hasSeq && (e >= loadVal);
`else
    carryExp = busyExp && (e == loadVal);
`endif
    checkValue({tag, ".Busy"},  {31'd0, Busy},  {31'd0, busyExp});
    checkValue({tag, ".Count"}, {30'd0, Count}, countExp);
    checkValue({tag, ".Carry"}, {31'd0, Carry}, {31'd0, carryExp});
  endtask

  // One clock: drive at the falling edge, update the model at the rising
  // edge, check at the next falling edge.
  task automatic step(input bit ld, input int v, input string tag);
    Load      = ld;
    LoadValue = v[WIDTH-1:0];
    @(posedge Clk);
    if (Reset && ld) begin
      hasSeq   = 1'b1;
      loadEdge = edgeCount;
      loadVal  = v;
      $display("load value=%0d at edge %0d", v, edgeCount);
    end
    edgeCount++;
    @(negedge Clk);
    checkOutputs(tag);
  endtask

  // Asserts reset between edges and checks the immediate clear.
  task automatic asyncReset(input int holdCycles, input string tag);
    #2 Reset = 1'b0;
    hasSeq = 1'b0;
    #1 checkOutputs({tag, ".async"});
    @(negedge Clk);
    for (int i = 0; i < holdCycles; i++) step(1'b1, MAXV, {tag, ".held"});
    Reset = 1'b1;
    $display("reset pulse released at edge %0d", edgeCount);
  endtask

  initial begin
    Reset     = 1'b0;
    Load      = 1'b1;
    LoadValue = 2'd3;
    @(negedge Clk);
    checkValue("reset.Count", {30'd0, Count}, 32'd0);
    checkValue("reset.Busy",  {31'd0, Busy},  32'd0);
    checkValue("reset.Carry", {31'd0, Carry}, 32'd0);
    step(1'b1, 3, "reset_load");
    step(1'b1, 3, "reset_load");
    Reset = 1'b1;
    step(1'b0, 0, "idle_after_reset");

    // LoadValue=1: two cycles in the wait state.
    step(1'b1, 1, "v1");
    for (int i = 0; i < 3; i++) step(1'b0, 0, "v1");
    // LoadValue=0: Carry immediately after the load edge.
    step(1'b1, 0, "v0");
    for (int i = 0; i < 2; i++) step(1'b0, 0, "v0");
    // Full-range count 3,2,1,0.
    step(1'b1, 3, "v3");
    for (int i = 0; i < 5; i++) step(1'b0, 0, "v3");
    // Reload when Count=1, then reload on the Carry cycle.
    step(1'b1, 3, "reload");
    step(1'b0, 0, "reload");
    step(1'b0, 0, "reload");
    step(1'b1, 2, "reload_mid");
    step(1'b0, 0, "reload_mid");
    step(1'b0, 0, "reload_mid");
    step(1'b1, 1, "reload_carry");
    for (int i = 0; i < 3; i++) step(1'b0, 0, "reload_carry");
    // Asynchronous reset while Count=2.
    step(1'b1, 3, "abort");
    step(1'b0, 0, "abort");
    asyncReset(2, "abort");
    step(1'b0, 0, "after_abort");
    // Expiry followed by several idle cycles, then a fresh load.
    step(1'b1, 1, "expire");
    for (int i = 0; i < 7; i++) step(1'b0, 0, "expire");
    step(1'b1, 2, "expire_reload");
    step(1'b0, 0, "expire_reload");

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        asyncReset($urandom_range(0, 2), "rand_reset");
      end else begin
        step($urandom_range(0, 3) == 0, $urandom_range(0, MAXV), "rand");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
